// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with prescaler, one-shot/auto-reload modes and
// per-channel maskable interrupts, accessed through a word-addressed register port.
module multi_timer #(
    parameter int NCH   = 2,
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:2]    Addr,
    input  logic           WE,
    input  logic [31:0]    Din,
    output logic [31:0]    Dout,
    output logic [NCH-1:0] IRQ,
    output logic           IRQ_any
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

    localparam logic [1:0] R_CTRL      = 2'd0;
    localparam logic [1:0] R_PRESET    = 2'd1;
    localparam logic [1:0] R_COUNT     = 2'd2;
    localparam logic [1:0] R_STATUS    = 2'd3;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_e           state_q  [NCH];
    state_e           state_d  [NCH];
    logic [7:0]       psc_q    [NCH];
    logic [7:0]       psc_d    [NCH];
    logic [7:0]       pcnt_q   [NCH];
    logic [7:0]       pcnt_d   [NCH];
    logic [1:0]       mode_q   [NCH];
    logic [1:0]       mode_d   [NCH];
    logic [WIDTH-1:0] preset_q [NCH];
    logic [WIDTH-1:0] preset_d [NCH];
    logic [WIDTH-1:0] count_q  [NCH];
    logic [WIDTH-1:0] count_d  [NCH];
    logic [NCH-1:0]   im_q, im_d;
    logic [NCH-1:0]   en_q, en_d;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   wr_hit, pend_set, pend_clr;

    logic [1:0] reg_sel;
    logic [2:0] ch_sel;
    logic       ch_valid;
    logic       unused_bits;

    assign reg_sel     = Addr[3:2];
    assign ch_sel      = Addr[6:4];
    assign ch_valid    = (int'(ch_sel) < NCH);
    assign unused_bits = ^{Addr[31:7], Din};

    // NOTE: every variable gets its default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c]  = state_q[c];
            psc_d[c]    = psc_q[c];
            pcnt_d[c]   = pcnt_q[c];
            mode_d[c]   = mode_q[c];
            preset_d[c] = preset_q[c];
            count_d[c]  = count_q[c];
            im_d[c]     = im_q[c];
            en_d[c]     = en_q[c];
            pend_set[c] = 1'b0;
            wr_hit[c]   = WE && ch_valid && (int'(ch_sel) == c);
            pend_clr[c] = wr_hit[c] && (reg_sel == R_STATUS) && Din[0];

            // A CTRL/PRESET write restarts the channel from IDLE and pre-empts this
            // cycle's FSM action, including the one-shot EN clear in INT.
            if (wr_hit[c] && (reg_sel == R_CTRL)) begin
                psc_d[c]   = Din[15:8];
                im_d[c]    = Din[3];
                mode_d[c]  = Din[2:1];
                en_d[c]    = Din[0];
                state_d[c] = S_IDLE;
            end else if (wr_hit[c] && (reg_sel == R_PRESET)) begin
                preset_d[c] = Din[WIDTH-1:0];
                state_d[c]  = S_IDLE;
            end else begin
                case (state_q[c])
                    S_IDLE: if (en_q[c]) state_d[c] = S_LOAD;
                    S_LOAD: begin
                        count_d[c] = preset_q[c];
                        pcnt_d[c]  = 8'd0;
                        state_d[c] = S_CNT;
                    end
                    S_CNT: begin
                        if (!en_q[c]) begin
                            state_d[c] = S_IDLE;
                        end else if (pcnt_q[c] == psc_q[c]) begin
                            pcnt_d[c] = 8'd0;
                            // COUNT of 0 or 1 both expire, so PRESET=0 acts as 1.
                            if (count_q[c] > WIDTH'(1)) begin
                                count_d[c] = count_q[c] - WIDTH'(1);
                            end else begin
                                count_d[c]  = '0;
                                pend_set[c] = 1'b1;
                                state_d[c]  = S_INT;
                            end
                        end else begin
                            pcnt_d[c] = pcnt_q[c] + 8'd1;
                        end
                    end
                    S_INT: begin
                        if (mode_q[c] == MODE_RELOAD) begin
                            state_d[c] = S_LOAD;
                        end else begin
                            en_d[c]    = 1'b0;
                            state_d[c] = S_IDLE;
                        end
                    end
                    default: state_d[c] = S_IDLE;
                endcase
            end

            // Expiry wins over a same-edge software clear.
            pend_d[c] = pend_set[c] | (pend_q[c] & ~pend_clr[c]);
        end
    end

    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked
    // block only; sequential state uses non-blocking assignments throughout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= S_IDLE;
                psc_q[c]    <= '0;
                pcnt_q[c]   <= '0;
                mode_q[c]   <= '0;
                preset_q[c] <= '0;
                count_q[c]  <= '0;
            end
            im_q   <= '0;
            en_q   <= '0;
            pend_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= state_d[c];
                psc_q[c]    <= psc_d[c];
                pcnt_q[c]   <= pcnt_d[c];
                mode_q[c]   <= mode_d[c];
                preset_q[c] <= preset_d[c];
                count_q[c]  <= count_d[c];
            end
            im_q   <= im_d;
            en_q   <= en_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        Dout = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_valid && (int'(ch_sel) == c)) begin
                case (reg_sel)
                    R_CTRL:   Dout = {16'd0, psc_q[c], 4'd0, im_q[c], mode_q[c], en_q[c]};
                    R_PRESET: Dout = 32'(preset_q[c]);
                    R_COUNT:  Dout = 32'(count_q[c]);
                    R_STATUS: Dout = {31'd0, pend_q[c]};
                    default:  Dout = '0;
                endcase
            end
        end
    end

    assign IRQ     = pend_q & im_q;
    assign IRQ_any = |IRQ;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed timing scenarios plus random register
// traffic, compared every cycle against a schedule-based reference model.
module tb_multi_timer;

    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:2]    Addr;
    logic           WE;
    logic [31:0]    Din;
    logic [31:0]    Dout;
    logic [NCH-1:0] IRQ;
    logic           IRQ_any;

    logic [31:2]    a8_addr;
    logic           a8_we;
    logic [31:0]    a8_din;
    logic [31:0]    a8_dout;
    logic [0:0]     a8_irq;
    logic           a8_irq_any;

    always #5 clk = ~clk;

    multi_timer #(.NCH(NCH), .WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .IRQ(IRQ), .IRQ_any(IRQ_any)
    );

    multi_timer #(.NCH(1), .WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .Addr(a8_addr), .WE(a8_we), .Din(a8_din),
        .Dout(a8_dout), .IRQ(a8_irq), .IRQ_any(a8_irq_any)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a running channel is described by the edge at which COUNT is
    // loaded; COUNT and the expiry edge follow from that by arithmetic.
    longint      edge_n;
    bit          m_run   [NCH];
    longint      m_tload [NCH];
    logic [31:0] m_hold  [NCH];
    logic [31:0] m_preset[NCH];
    int          m_psc   [NCH];
    int          m_mode  [NCH];
    int          m_im    [NCH];
    int          m_en    [NCH];
    int          m_pend  [NCH];

    function automatic logic [29:0] wa(input int ch, input int r);
        return 30'(ch * 4 + r);
    endfunction

    function automatic longint expiry_edge(input int c);
        longint k;
        k = (m_preset[c] == 0) ? 1 : longint'(m_preset[c]);
        return m_tload[c] + k * longint'(m_psc[c] + 1);
    endfunction

    function automatic logic [31:0] count_at(input int c, input longint m);
        longint per, j;
        if (m_run[c] && m >= m_tload[c]) begin
            per = longint'(m_psc[c] + 1);
            j   = m - m_tload[c];
            if (m >= expiry_edge(c)) return 32'd0;
            return m_preset[c] - 32'(j / per);
        end
        return m_hold[c];
    endfunction

    function automatic logic [31:0] model_read(input logic [29:0] a);
        int ch, r;
        ch = int'(a[4:2]);
        r  = int'(a[1:0]);
        if (ch >= NCH) return 32'd0;
        case (r)
            0:       return 32'((m_psc[ch] << 8) | (m_im[ch] << 3) | (m_mode[ch] << 1) | m_en[ch]);
            1:       return m_preset[ch];
            2:       return count_at(ch, edge_n);
            default: return 32'(m_pend[ch]);
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_irq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (m_pend[c] != 0) && (m_im[c] != 0);
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_tload[c] = 0; m_hold[c] = 0; m_preset[c] = 0;
            m_psc[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_en[c] = 0; m_pend[c] = 0;
        end
    endtask

    task automatic model_step(input bit rst_n, input bit we, input logic [29:0] a,
                              input logic [31:0] d);
        int  r;
        bit  hit, set, clr;
        edge_n++;
        if (!rst_n) begin
            model_clear();
            return;
        end
        r = int'(a[1:0]);
        for (int c = 0; c < NCH; c++) begin
            hit = we && (int'(a[4:2]) == c);
            set = 0;
            clr = hit && (r == 3) && d[0];
            if (hit && (r == 0 || r == 1)) begin
                m_hold[c] = count_at(c, edge_n - 1);
                m_run[c]  = 0;
                if (r == 0) begin
                    m_psc[c] = int'(d[15:8]); m_im[c] = int'(d[3]);
                    m_mode[c] = int'(d[2:1]); m_en[c] = int'(d[0]);
                end else begin
                    m_preset[c] = d;
                end
            end else if (!m_run[c]) begin
                if (m_en[c] != 0) begin
                    m_run[c]   = 1;
                    m_tload[c] = edge_n + 1;
                end
            end else if (edge_n == expiry_edge(c)) begin
                set = 1;
            end else if (edge_n == expiry_edge(c) + 1) begin
                m_hold[c] = 32'd0;
                if (m_mode[c] == 1) begin
                    m_tload[c] = edge_n + 1;
                end else begin
                    m_en[c]  = 0;
                    m_run[c] = 0;
                end
            end
            m_pend[c] = (set || (m_pend[c] != 0 && !clr)) ? 1 : 0;
        end
    endtask

    task automatic do_cycle(input bit rst_n, input bit we, input logic [29:0] a,
                            input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        reset = rst_n; WE = we; Addr = a; Din = d;
        #1;
        rd = Dout;
        check("dout", 64'(Dout), 64'(model_read(a)));
        check("irq", 64'(IRQ), 64'(model_irq()));
        check("irq_any", 64'(IRQ_any), 64'(|model_irq()));
        @(posedge clk);
        model_step(rst_n, we, a, d);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        logic [31:0] x;
        do_cycle(1'b1, 1'b1, wa(ch, r), d, x);
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        do_cycle(1'b1, 1'b0, wa(ch, r), 32'd0, v);
    endtask

    task automatic wait_irq(input int ch, input int budget, output longint at);
        logic [31:0] v;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            rd(ch, 2, v);
            if (IRQ[ch] === 1'b1) begin
                at = edge_n;
                break;
            end
        end
        if (at < 0) check("irq_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] v, d;
        longint      e0, at, at2;
        int          sel, ch, r;

        reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0;
        a8_we = 1'b0; a8_addr = '0; a8_din = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        edge_n = 0;

        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 4; k++) begin
                rd(c, k, v);
                check("reset_reg", 64'(v), 64'd0);
            end
        check("reset_irq", 64'(IRQ), 64'd0);

        // One-shot: PRESET=5, CTRL=0x9
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h9);
        e0 = edge_n;
        wait_irq(0, 20, at);
        check("oneshot_edge", 64'(at - e0), 64'd7);
        rd(0, 0, v); rd(0, 0, v);
        check("oneshot_ctrl", 64'(v), 64'h8);
        rd(0, 2, v);
        check("oneshot_count", 64'(v), 64'd0);
        wr(0, 3, 32'd1);

        // Auto-reload with PSC=1: period 3*2+2
        wr(1, 1, 32'd3);
        wr(1, 0, 32'h10B);
        e0 = edge_n;
        wait_irq(1, 30, at);
        check("reload_first", 64'(at - e0), 64'd8);
        wr(1, 3, 32'd1);
        check("reload_cleared", 64'(IRQ[1]), 64'd0);
        wait_irq(1, 30, at2);
        check("reload_period", 64'(at2 - at), 64'd8);
        wr(1, 0, 32'd0);
        wr(1, 3, 32'd1);

        // Independence: ch1 written every cycle while ch0 counts
        wr(0, 1, 32'd4);
        wr(0, 0, 32'h9);
        e0 = edge_n;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            wr(1, $urandom_range(0, 1), d);
            if (IRQ[0] === 1'b1) begin
                at = edge_n;
                break;
            end
        end
        check("indep_edge", 64'(at - e0), 64'd6);
        check("indep_irq_any", 64'(IRQ_any), 64'd1);
        wr(1, 0, 32'd0);
        wr(0, 3, 32'd1);

        // Same-edge collisions
        wr(0, 1, 32'd2);
        wr(0, 0, 32'h9);
        e0 = edge_n;
        rd(0, 3, v); rd(0, 3, v); rd(0, 3, v);
        wr(0, 3, 32'd1);
        check("collide_pend_edge", 64'(edge_n - e0), 64'd4);
        check("collide_pend", 64'(IRQ[0]), 64'd1);
        wr(0, 0, 32'h9);
        rd(0, 0, v);
        check("collide_en_kept", 64'(v), 64'h9);
        wr(0, 3, 32'd1);
        wait_irq(0, 20, at);
        check("collide_restart", 64'(at - e0), 64'd9);
        rd(0, 0, v); rd(0, 0, v);
        wr(0, 3, 32'd1);

        // PRESET=0 behaves as PRESET=1
        wr(0, 1, 32'd0);
        wr(0, 0, 32'h9);
        e0 = edge_n;
        wait_irq(0, 20, at);
        check("preset0_edge", 64'(at - e0), 64'd3);
        rd(0, 0, v); rd(0, 0, v);
        wr(0, 3, 32'd1);

        // Disable mid-count freezes COUNT
        wr(0, 1, 32'd10);
        wr(0, 0, 32'h1);
        repeat (5) rd(0, 2, v);
        wr(0, 0, 32'h0);
        repeat (3) rd(0, 2, v);
        check("frozen_count", 64'(v), 64'd7);

        // Channel index >= NCH
        wr(2, 1, 32'hFFFF_FFFF);
        wr(7, 0, 32'hFFFF);
        rd(2, 1, v);
        check("badch_preset", 64'(v), 64'd0);
        rd(7, 0, v);
        check("badch_ctrl", 64'(v), 64'd0);

        // WIDTH=8 instance: PRESET truncation and CTRL field masking
        a8_we = 1'b1; a8_addr = 30'd1; a8_din = 32'h1FF;
        rd(0, 0, v);
        a8_addr = 30'd0; a8_din = 32'hFFF6;
        rd(0, 0, v);
        a8_we = 1'b0; a8_addr = 30'd1;
        #1;
        check("w8_preset", 64'(a8_dout), 64'hFF);
        a8_addr = 30'd0;
        #1;
        check("w8_ctrl", 64'(a8_dout), 64'hFF06);
        check("w8_irq", 64'({a8_irq, a8_irq_any}), 64'd0);

        // Reset mid-count
        wr(0, 1, 32'd20);
        wr(0, 0, 32'h9);
        repeat (5) rd(0, 2, v);
        do_cycle(1'b0, 1'b1, wa(0, 0), 32'h9, v);
        for (int k = 0; k < 4; k++) begin
            rd(0, k, v);
            check("midreset_reg", 64'(v), 64'd0);
        end
        repeat (5) rd(0, 2, v);
        check("midreset_count", 64'(v), 64'd0);
        check("midreset_irq", 64'(IRQ), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 399);
            ch  = $urandom_range(0, 3);
            r   = $urandom_range(0, 3);
            d   = $urandom;
            if (sel == 0) begin
                do_cycle(1'b0, 1'($urandom_range(0, 1)), wa(ch, r), d, v);
            end else if (sel < 56) begin
                if (r == 0) d[15:8] = 8'($urandom_range(0, 3));
                if (r == 1) d = $urandom_range(0, 12);
                do_cycle(1'b1, 1'b1, wa(ch, r), d, v);
            end else begin
                do_cycle(1'b1, 1'b0, wa(ch, r), d, v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
